// File: rtl/bananachine_pkg.sv
// Shared encodings for the bananachine multicycle controller: opcodes, function
// codes, ALU control codes, writeback source selects and FSM state encoding.
package bananachine_pkg;

  localparam int ALU_WIDTH = 6;
  localparam int SRC_WIDTH = 2;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_LDST  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  // Immediate opcodes reuse the R-type function field values.
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  localparam logic [ALU_WIDTH-1:0] ALU_NOP    = 6'b000000;
  localparam logic [ALU_WIDTH-1:0] ALU_AND    = 6'b000001;
  localparam logic [ALU_WIDTH-1:0] ALU_OR     = 6'b000010;
  localparam logic [ALU_WIDTH-1:0] ALU_XOR    = 6'b000011;
  localparam logic [ALU_WIDTH-1:0] ALU_ADD    = 6'b000101;
  localparam logic [ALU_WIDTH-1:0] ALU_SUB    = 6'b001001;
  localparam logic [ALU_WIDTH-1:0] ALU_CMP    = 6'b001011;
  localparam logic [ALU_WIDTH-1:0] ALU_PASS_B = 6'b111111;

  localparam logic [SRC_WIDTH-1:0] WB_SRC_ALU = 2'd0;
  localparam logic [SRC_WIDTH-1:0] WB_SRC_MEM = 2'd1;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_TRAP
  } state_t;

  function automatic logic is_compare(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_CMPI) || ((op == OP_RTYPE) && (ext == EXT_CMP));
  endfunction

endpackage

// File: rtl/alu_cont_decode.sv
// Maps {op_code, ext_op_code} to an ALU function code and flags whether the
// instruction is one this controller can execute.
module alu_cont_decode
  import bananachine_pkg::*;
(
  input  logic [3:0]           op_code,
  input  logic [3:0]           ext_op_code,
  output logic [ALU_WIDTH-1:0] alu_cont,
  output logic                 valid
);

  logic [3:0] func;

  always_comb begin
    func     = (op_code == OP_RTYPE) ? ext_op_code : op_code;
    alu_cont = ALU_NOP;
    valid    = 1'b1;
    case (func)
      EXT_AND: alu_cont = ALU_AND;
      EXT_OR:  alu_cont = ALU_OR;
      EXT_XOR: alu_cont = ALU_XOR;
      EXT_ADD: alu_cont = ALU_ADD;
      EXT_SUB: alu_cont = ALU_SUB;
      EXT_CMP: alu_cont = ALU_CMP;
      EXT_MOV: alu_cont = ALU_PASS_B;
      default: valid = 1'b0;
    endcase
    // Load/store address generation passes the base register straight through.
    if (op_code == OP_LDST) begin
      alu_cont = ALU_PASS_B;
      valid    = (ext_op_code == EXT_LOAD) || (ext_op_code == EXT_STOR);
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle fetch/decode/execute/memory/writeback controller; every output is
// registered and set on the edge that enters the state it belongs to.
//
// state      | meaning
// S_FETCH    | PC addresses memory, IR loads while run=1
// S_DECODE   | IR valid, pick execution path
// S_EXEC_R   | ALU on Rdest, Rsrc
// S_EXEC_I   | ALU on Rdest, imm8 (MOVI: zero, imm8)
// S_WB_ALU   | write ALU result, bump PC
// S_MEM_ADDR | register drives memory address
// S_MEM_READ | wait out synchronous read latency
// S_MEM_WB   | write memory data, bump PC
// S_MEM_WRITE| single-cycle store strobe, bump PC
// S_TRAP     | flag illegal opcode, skip word
module control_fsm
  import bananachine_pkg::*;
#(
  parameter int ALU_W = ALU_WIDTH,
  parameter int SRC_W = SRC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       op_code,
  input  logic [3:0]       ext_op_code,
  output logic             ir_en,
  output logic             mem_addr_sel,
  output logic             pc_en,
  output logic             pc_src,
  output logic             reg_write,
  output logic [SRC_W-1:0] reg_write_src,
  output logic             alu_A_src,
  output logic             alu_B_src,
  output logic [ALU_W-1:0] alu_cont,
  output logic             wren_a,
  output logic             illegal
);

  state_t               state;
  logic                 is_cmp;
  logic                 is_stor;
  logic [ALU_WIDTH-1:0] dec_alu;
  logic                 dec_valid;

  alu_cont_decode u_dec (
    .op_code     (op_code),
    .ext_op_code (ext_op_code),
    .alu_cont    (dec_alu),
    .valid       (dec_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      is_cmp        <= 1'b0;
      is_stor       <= 1'b0;
      ir_en         <= 1'b0;
      mem_addr_sel  <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= 1'b0;
      reg_write     <= 1'b0;
      reg_write_src <= WB_SRC_ALU;
      alu_A_src     <= 1'b0;
      alu_B_src     <= 1'b0;
      alu_cont      <= ALU_NOP;
      wren_a        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      ir_en         <= 1'b0;
      mem_addr_sel  <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= 1'b0;
      reg_write     <= 1'b0;
      reg_write_src <= WB_SRC_ALU;
      alu_A_src     <= 1'b0;
      alu_B_src     <= 1'b0;
      alu_cont      <= ALU_NOP;
      wren_a        <= 1'b0;
      case (state)
        // ir_en is run one cycle late, so advancing on (run && ir_en) guarantees
        // the IR was actually loaded during the FETCH cycle being left.
        S_FETCH: begin
          if (run && ir_en) state <= S_DECODE;
          else              ir_en <= run;
        end
        S_DECODE: begin
          is_cmp  <= is_compare(op_code, ext_op_code);
          is_stor <= (ext_op_code == EXT_STOR);
          if (!dec_valid) begin
            state   <= S_TRAP;
            illegal <= 1'b1;
            pc_en   <= 1'b1;
          end else if (op_code == OP_LDST) begin
            state        <= S_MEM_ADDR;
            mem_addr_sel <= 1'b1;
            alu_cont     <= ALU_PASS_B;
          end else if (op_code == OP_RTYPE) begin
            state     <= S_EXEC_R;
            alu_A_src <= 1'b1;
            alu_cont  <= dec_alu;
          end else begin
            state     <= S_EXEC_I;
            alu_A_src <= (op_code != OP_MOVI);
            alu_B_src <= 1'b1;
            alu_cont  <= dec_alu;
          end
        end
        S_EXEC_R, S_EXEC_I: begin
          state     <= S_WB_ALU;
          alu_A_src <= alu_A_src;
          alu_B_src <= alu_B_src;
          alu_cont  <= alu_cont;
          reg_write <= !is_cmp;
          pc_en     <= 1'b1;
        end
        S_MEM_ADDR: begin
          mem_addr_sel <= 1'b1;
          alu_cont     <= ALU_PASS_B;
          if (is_stor) begin
            state  <= S_MEM_WRITE;
            wren_a <= 1'b1;
            pc_en  <= 1'b1;
          end else begin
            state <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          state         <= S_MEM_WB;
          reg_write     <= 1'b1;
          reg_write_src <= WB_SRC_MEM;
          pc_en         <= 1'b1;
        end
        S_WB_ALU, S_MEM_WB, S_MEM_WRITE, S_TRAP: begin
          state <= S_FETCH;
          ir_en <= run;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a table of instructions expands into
// per-cycle expected output records held in a scoreboard queue.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] op_code;
  logic [3:0] ext_op_code;
  logic       ir_en, mem_addr_sel, pc_en, pc_src, reg_write;
  logic [1:0] reg_write_src;
  logic       alu_A_src, alu_B_src;
  logic [5:0] alu_cont;
  logic       wren_a, illegal;

  control_fsm #(.ALU_W(6), .SRC_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .op_code       (op_code),
    .ext_op_code   (ext_op_code),
    .ir_en         (ir_en),
    .mem_addr_sel  (mem_addr_sel),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .reg_write_src (reg_write_src),
    .alu_A_src     (alu_A_src),
    .alu_B_src     (alu_B_src),
    .alu_cont      (alu_cont),
    .wren_a        (wren_a),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir;
    logic       mas;
    logic       pc;
    logic       psrc;
    logic       rw;
    logic [1:0] src;
    logic       a;
    logic       b;
    logic [5:0] alu;
    logic       wren;
    logic       ill;
  } obs_t;

  localparam int K_ALU  = 0;
  localparam int K_LOAD = 1;
  localparam int K_STOR = 2;
  localparam int K_TRAP = 3;

  typedef struct {
    logic [15:0] instr;
    int          kind;
    logic        a;
    logic        b;
    logic [5:0]  alu;
    logic        wr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ill_m  = 1'b0;
  int   cyc    = 0;

  function automatic obs_t mk(logic ir, logic mas, logic pc, logic rw, logic [1:0] src,
                              logic a, logic b, logic [5:0] alu, logic wren, logic il);
    obs_t o;
    o = '{ir: ir, mas: mas, pc: pc, psrc: 1'b0, rw: rw, src: src,
          a: a, b: b, alu: alu, wren: wren, ill: il};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{ir: ir_en, mas: mem_addr_sel, pc: pc_en, psrc: pc_src, rw: reg_write,
          src: reg_write_src, a: alu_A_src, b: alu_B_src, alu: alu_cont,
          wren: wren_a, ill: illegal};
    return o;
  endfunction

  task automatic push_trace(input vec_t v, output int n);
    int start;
    start = exp_q.size();
    exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 6'h00, 0, ill_m));
    exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 6'h00, 0, ill_m));
    case (v.kind)
      K_ALU: begin
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, v.a, v.b, v.alu, 0, ill_m));
        exp_q.push_back(mk(0, 0, 1, v.wr, 2'd0, v.a, v.b, v.alu, 0, ill_m));
      end
      K_LOAD: begin
        exp_q.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 6'h3F, 0, ill_m));
        exp_q.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 6'h3F, 0, ill_m));
        exp_q.push_back(mk(0, 0, 1, 1, 2'd1, 0, 0, 6'h00, 0, ill_m));
      end
      K_STOR: begin
        exp_q.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 6'h3F, 0, ill_m));
        exp_q.push_back(mk(0, 1, 1, 0, 2'd0, 0, 0, 6'h3F, 1, ill_m));
      end
      default: begin
        ill_m = 1'b1;
        exp_q.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 6'h00, 0, 1'b1));
      end
    endcase
    n = exp_q.size() - start;
  endtask

  task automatic step(input string tag, output logic pc);
    obs_t got, want;
    @(posedge clk);
    #1;
    cyc++;
    got = sample();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cycle %0d: scoreboard empty, got=%h", tag, cyc, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got=%h expected=%h", tag, cyc, got, want);
      end
    end
    checks++;
    if (reg_write && wren_a) begin
      errors++;
      $display("FAIL %s cycle %0d: reg_write=%b wren_a=%b both high", tag, cyc, reg_write, wren_a);
    end
    pc = pc_en;
  endtask

  task automatic drive(input logic [15:0] instr);
    op_code     = instr[15:12];
    ext_op_code = instr[7:4];
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    int   pcs;
    logic p;
    string tag;
    tag = $sformatf("instr_%h", v.instr);
    drive(v.instr);
    push_trace(v, n);
    pcs = 0;
    for (int i = 0; i < n; i++) begin
      step(tag, p);
      pcs += int'(p);
    end
    checks++;
    if (pcs != 1) begin
      errors++;
      $display("FAIL %s pc_en_pulses: got=%0d expected=1", tag, pcs);
    end
  endtask

  task automatic idle(input string tag, input int n);
    logic p;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 6'h00, 0, ill_m));
      step(tag, p);
    end
  endtask

  initial begin
    logic p;
    int   n;
    obs_t got;

    vecs[0]  = '{16'hD103, K_ALU,  1'b0, 1'b1, 6'h3F, 1'b1};
    vecs[1]  = '{16'h0152, K_ALU,  1'b1, 1'b0, 6'h05, 1'b1};
    vecs[2]  = '{16'h4144, K_STOR, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[3]  = '{16'h4304, K_LOAD, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[4]  = '{16'h5207, K_ALU,  1'b1, 1'b1, 6'h05, 1'b1};
    vecs[5]  = '{16'h0B91, K_ALU,  1'b1, 1'b0, 6'h09, 1'b1};
    vecs[6]  = '{16'hB105, K_ALU,  1'b1, 1'b1, 6'h0B, 1'b0};
    vecs[7]  = '{16'h0312, K_ALU,  1'b1, 1'b0, 6'h01, 1'b1};
    vecs[8]  = '{16'h1234, K_ALU,  1'b1, 1'b1, 6'h01, 1'b1};
    vecs[9]  = '{16'h06B2, K_ALU,  1'b1, 1'b0, 6'h0B, 1'b0};
    vecs[10] = '{16'h3A0F, K_ALU,  1'b1, 1'b1, 6'h03, 1'b1};
    vecs[11] = '{16'hF000, K_TRAP, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[12] = '{16'h0152, K_ALU,  1'b1, 1'b0, 6'h05, 1'b1};
    vecs[13] = '{16'h4124, K_TRAP, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[14] = '{16'h00F0, K_TRAP, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[15] = '{16'h2325, K_ALU,  1'b1, 1'b1, 6'h02, 1'b1};
    vecs[16] = '{16'h0D21, K_ALU,  1'b1, 1'b0, 6'h02, 1'b1};

    reset = 1'b1;
    run   = 1'b0;
    drive(16'h0000);
    idle("in_reset", 2);
    @(negedge clk);
    reset = 1'b0;
    idle("run_low_after_reset", 3);

    run = 1'b1;
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // run dropped at the end of an instruction: park in FETCH, IR not loaded
    run = 1'b0;
    idle("run_low_hold", 3);

    // run dropped mid-LOAD: the load still completes, then FETCH holds
    run = 1'b1;
    drive(16'h4304);
    push_trace(vecs[3], n);
    step("load_fetch", p);
    step("load_decode", p);
    run = 1'b0;
    for (int i = 2; i < n; i++) step("load_tail_run_low", p);
    idle("after_load_run_low", 3);

    // reset asserted while in EXEC_R
    run = 1'b1;
    drive(16'h0152);
    push_trace(vecs[1], n);
    step("rst_fetch", p);
    step("rst_decode", p);
    step("rst_exec_r", p);
    exp_q.delete();
    reset = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== mk(0, 0, 0, 0, 2'd0, 0, 0, 6'h00, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_exec: got=%h expected=%h", got,
               mk(0, 0, 0, 0, 2'd0, 0, 0, 6'h00, 0, 0));
    end
    ill_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got=%0d leftover expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
